disp_mode_ctrl: RTL and testbench

- Display-mode controller for the clock display mux.
- Turns a raw, bouncy mode push-button into a clean press event.
- Steps through three display modes and drives the mux select lines `sec` and `hour`.
- Returns the display to HH:MM on its own after a set number of 1 Hz ticks with no button activity.

---
 rtl/disp_mode_ctrl_pkg.sv | 15 +
 rtl/disp_mode_ctrl_btn_debounce.sv | 33 +++
 rtl/disp_mode_ctrl.sv | 55 +++++
 tb/tb_disp_mode_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/disp_mode_ctrl_pkg.sv
// disp_mode_ctrl_pkg: mode codes, mux select levels and mode sequencing shared by the display-mode logic
package disp_mode_ctrl_pkg;
  localparam int MODE_BIT_WIDTH = 2;
  localparam logic ENABLED = 1'b1;
  localparam logic DISABLED = 1'b0;
  typedef enum logic [MODE_BIT_WIDTH-1:0] {
    MODE_HHMM = 2'd0,
    MODE_MMSS = 2'd1,
    MODE_AMPM = 2'd2
  } mode_e;
  // Unused encodings fall through to HHMM so a corrupted state self-recovers
  function automatic mode_e next_mode(input mode_e m);
    return m == MODE_HHMM ? MODE_MMSS : m == MODE_MMSS ? MODE_AMPM : MODE_HHMM;
  endfunction
endpackage

// File: rtl/disp_mode_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, level debounce and one-pulse press on each accepted rising level
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_lvl,
  output logic o_press
);
  logic r_s1, r_s2, r_lvl, r_press;
  logic [7:0] r_cnt;
  logic w_diff, w_flip;
  assign w_diff = r_s2 != r_lvl;
  assign w_flip = w_diff && r_cnt == 8'(DEB_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_lvl <= 1'b0;
      r_cnt <= 8'd0;
      r_press <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      r_cnt <= (w_diff && !w_flip) ? r_cnt + 8'd1 : 8'd0;
      r_lvl <= r_lvl ^ w_flip;
      r_press <= w_flip && !r_lvl;
    end
  end
  assign o_lvl = r_lvl;
  assign o_press = r_press;
endmodule

// File: rtl/disp_mode_ctrl.sv
// disp_mode_ctrl: cycles HHMM/MMSS/AMPM on debounced presses and falls back to HHMM after TIMEOUT_S idle ticks
module disp_mode_ctrl
  import disp_mode_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT_S = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btn_mode,
  input  logic                      tick_1hz,
  output logic                      sec,
  output logic                      hour,
  output logic [MODE_BIT_WIDTH-1:0] mode,
  output logic                      press
);
  mode_e r_state, w_next;
  logic [7:0] r_to_cnt, w_to_next;
  logic w_press, w_lvl;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_mode),
    .o_lvl  (w_lvl),
    .o_press(w_press)
  );
  // A press outranks a same-cycle timeout tick
  always_comb begin
    w_next = r_state;
    w_to_next = r_to_cnt;
    if (w_press) begin
      w_next = next_mode(r_state);
      w_to_next = 8'd0;
    end else if (r_state != MODE_MMSS && r_state != MODE_AMPM) begin
      w_next = MODE_HHMM;
      w_to_next = 8'd0;
    end else if (tick_1hz) begin
      w_next = r_to_cnt == 8'(TIMEOUT_S - 1) ? MODE_HHMM : r_state;
      w_to_next = r_to_cnt == 8'(TIMEOUT_S - 1) ? 8'd0 : r_to_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MODE_HHMM;
      r_to_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      r_to_cnt <= w_to_next;
    end
  end
  assign mode = r_state;
  assign sec = r_state == MODE_MMSS ? ENABLED : DISABLED;
  assign hour = r_state == MODE_AMPM ? ENABLED : DISABLED;
  assign press = w_press;
endmodule

// File: tb/tb_disp_mode_ctrl.sv
// tb_disp_mode_ctrl: directed stimulus with a run-length/modulo-3 reference model checked every cycle
module tb_disp_mode_ctrl;
  localparam int DEB = 4;
  localparam int TO = 3;
  logic clk = 1'b0, rst_n = 1'b0, btn_mode = 1'b0, tick_1hz = 1'b0;
  logic sec, hour, press;
  logic [1:0] mode;
  int errors = 0, checks = 0;
  disp_mode_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_S(TO)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .tick_1hz(tick_1hz),
    .sec(sec), .hour(hour), .mode(mode), .press(press)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the button level is accepted once the synchronized input has
  // disagreed with it for DEB consecutive samples; mode advances modulo 3.
  logic m_s1, m_s2, m_lvl, m_press;
  int m_run, m_mode, m_ticks;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= 0; m_s2 <= 0; m_lvl <= 0; m_press <= 0;
      m_run <= 0; m_mode <= 0; m_ticks <= 0;
    end else begin
      m_s1 <= btn_mode;
      m_s2 <= m_s1;
      if (m_s2 != m_lvl && m_run + 1 >= DEB) begin
        m_lvl <= m_s2; m_run <= 0; m_press <= m_s2;
      end else begin
        m_run <= (m_s2 != m_lvl) ? m_run + 1 : 0; m_press <= 0;
      end
      if (m_press) begin
        m_mode <= (m_mode + 1) % 3; m_ticks <= 0;
      end else if (m_mode != 0 && tick_1hz) begin
        if (m_ticks + 1 == TO) begin m_mode <= 0; m_ticks <= 0; end
        else m_ticks <= m_ticks + 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("model_mode", int'(mode), m_mode);
      chk("model_sec", int'(sec), int'(m_mode == 1));
      chk("model_hour", int'(hour), int'(m_mode == 2));
      chk("model_press", int'(press), int'(m_press));
      chk("sec_hour_exclusive", int'(sec & hour), 0);
    end
  end

  task automatic hold(input logic v, input int n);
    @(negedge clk); btn_mode = v;
    repeat (n - 1) @(negedge clk);
  endtask
  task automatic do_press();
    hold(1'b1, 10);
    hold(1'b0, 10);
  endtask
  task automatic tick();
    @(negedge clk); tick_1hz = 1'b1;
    @(negedge clk); tick_1hz = 1'b0;
  endtask

  int presses;
  initial begin
    repeat (5) @(negedge clk);
    chk("in_reset_mode", int'(mode), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_mode", int'(mode), 0);
    chk("reset_sec", int'(sec), 0);
    chk("reset_hour", int'(hour), 0);
    chk("reset_press", int'(press), 0);
    // Clean press: btn rises just before edge 1
    @(negedge clk); btn_mode = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("clean_press_e%0d", k), int'(press), int'(k == 6));
      chk($sformatf("clean_mode_e%0d", k), int'(mode), k >= 7 ? 1 : 0);
    end
    chk("clean_sec", int'(sec), 1);
    chk("clean_hour", int'(hour), 0);
    hold(1'b0, 10);
    // Bounce: 3-clk pulses are rejected, a long hold gives one press
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    presses = 0;
    fork
      repeat (60) begin @(posedge clk); #1; presses += int'(press); end
      begin
        hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3);
        chk("bounce_mode", int'(mode), 0);
        hold(1'b1, 10); hold(1'b0, 10);
      end
    join
    chk("bounce_presses", presses, 1);
    chk("bounce_mode_after_hold", int'(mode), 1);
    // Full cycle
    do_press(); chk("cycle_ampm", int'(mode), 2); chk("cycle_hour", int'(hour), 1);
    do_press(); chk("cycle_hhmm", int'(mode), 0); chk("cycle_sec0", int'(sec), 0);
    // Timeout
    do_press(); chk("to_mmss", int'(mode), 1);
    tick(); tick(); chk("to_after2", int'(mode), 1);
    tick(); chk("to_after3", int'(mode), 0);
    tick(); tick(); chk("to_idle", int'(mode), 0);
    // Collision: in AMPM after 2 ticks, 3rd tick coincides with press
    do_press(); do_press(); chk("col_ampm", int'(mode), 2);
    tick(); tick();
    @(negedge clk); btn_mode = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); tick_1hz = 1'b1; chk("col_press", int'(press), 1);
    @(negedge clk); tick_1hz = 1'b0; chk("col_mode", int'(mode), 0);
    hold(1'b0, 10);
    // Restart: press clears the tick count
    do_press(); tick(); tick();
    do_press(); chk("rs_ampm", int'(mode), 2);
    tick(); tick(); chk("rs_after2", int'(mode), 2);
    tick(); chk("rs_after3", int'(mode), 0);
    // Asynchronous reset mid-run in AMPM
    do_press(); do_press(); chk("ar_ampm", int'(mode), 2);
    @(posedge clk); #3; rst_n = 1'b0; #1;
    chk("ar_mode", int'(mode), 0);
    chk("ar_hour", int'(hour), 0);
    chk("ar_sec", int'(sec), 0);
    chk("ar_press", int'(press), 0);
    // Release reset with the button already held: one press after debounce
    btn_mode = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_release_mode", int'(mode), 1);
    hold(1'b0, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
